// File: rtl/mandelbrot_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mandelbrot_pkg: shared FSM encoding and fixed-point constants         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package mandelbrot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Operands are signed 2.(WIDTH-2): two integer bits including sign.
  localparam int INT_BITS      = 2;
  localparam int DEFAULT_WIDTH = 8;
  localparam int ONE           = 1 << (DEFAULT_WIDTH - INT_BITS);

  function automatic int frac_bits(input int width);
    return width - INT_BITS;
  endfunction

  function automatic int fp_one(input int width);
    return 1 << frac_bits(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mandelbrot_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mandelbrot_alu: one z <- z^2 + c step plus |z|^2 > 4 escape flag      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mandelbrot_alu
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] zr,
  input  logic [WIDTH-1:0] zi,
  input  logic [WIDTH-1:0] cr,
  input  logic [WIDTH-1:0] ci,
  output logic [WIDTH-1:0] out_zr,
  output logic [WIDTH-1:0] out_zi,
  output logic             size
);

  localparam int c_FRAC = frac_bits(WIDTH);
  // 4.0 squared-domain threshold: 4 * ONE^2 == ONE << WIDTH.
  localparam logic [2*WIDTH:0] c_ESC_THR = (2*WIDTH+1)'(fp_one(WIDTH)) << WIDTH;

  logic signed [2*WIDTH-1:0] w_zr_x;
  logic signed [2*WIDTH-1:0] w_zi_x;
  logic signed [2*WIDTH-1:0] w_sq_r;
  logic signed [2*WIDTH-1:0] w_sq_i;
  logic signed [2*WIDTH-1:0] w_diff;
  logic signed [2*WIDTH-1:0] w_prod;
  logic        [2*WIDTH:0]   w_mag;
  logic                      w_unused;

  assign w_zr_x = {{WIDTH{zr[WIDTH-1]}}, zr};
  assign w_zi_x = {{WIDTH{zi[WIDTH-1]}}, zi};

  assign w_sq_r = w_zr_x * w_zr_x;
  assign w_sq_i = w_zi_x * w_zi_x;
  assign w_diff = w_sq_r - w_sq_i;
  assign w_prod = w_zr_x * w_zi_x;

  // Squares are non-negative, so an unsigned widened sum cannot overflow.
  assign w_mag = {1'b0, w_sq_r} + {1'b0, w_sq_i};
  assign size  = (w_mag > c_ESC_THR);

  // Re-align to 2.(WIDTH-2) by dropping fraction bits; 2*zr*zi uses one less shift.
  assign out_zr = w_diff[c_FRAC +: WIDTH] + cr;
  assign out_zi = w_prod[(c_FRAC-1) +: WIDTH] + ci;

  assign w_unused = ^{w_diff, w_prod};

endmodule
`default_nettype wire

// File: rtl/mandelbrot_iter_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mandelbrot_iter_ctrl: per-pixel escape-time iteration controller      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mandelbrot_iter_ctrl
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ITER_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_cr,
  input  logic [WIDTH-1:0]  in_ci,
  input  logic [ITER_W-1:0] in_max_iter,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ITER_W-1:0] out_iter,
  output logic              out_escaped
);

  state_t              r_state;
  logic [WIDTH-1:0]    r_cr;
  logic [WIDTH-1:0]    r_ci;
  logic [WIDTH-1:0]    r_zr;
  logic [WIDTH-1:0]    r_zi;
  logic [ITER_W-1:0]   r_iter;
  logic [ITER_W-1:0]   r_max_iter;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [ITER_W-1:0]   r_out_iter;
  logic                r_out_escaped;

  logic [WIDTH-1:0]    w_next_zr;
  logic [WIDTH-1:0]    w_next_zi;
  logic                w_size;

  mandelbrot_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .zr     (r_zr),
    .zi     (r_zi),
    .cr     (r_cr),
    .ci     (r_ci),
    .out_zr (w_next_zr),
    .out_zi (w_next_zi),
    .size   (w_size)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cr          <= '0;
      r_ci          <= '0;
      r_zr          <= '0;
      r_zi          <= '0;
      r_iter        <= '0;
      r_max_iter    <= '0;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_out_iter    <= '0;
      r_out_escaped <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_cr       <= in_cr;
            r_ci       <= in_ci;
            r_max_iter <= in_max_iter;
            r_zr       <= '0;
            r_zi       <= '0;
            r_iter     <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Escape outranks the limit, so a job escaping at max_iter reports escaped=1.
          if (w_size) begin
            r_out_iter    <= r_iter;
            r_out_escaped <= 1'b1;
            r_out_valid   <= 1'b1;
            r_state       <= ST_DONE;
          end else if (r_iter == r_max_iter) begin
            r_out_iter    <= r_max_iter;
            r_out_escaped <= 1'b0;
            r_out_valid   <= 1'b1;
            r_state       <= ST_DONE;
          end else begin
            r_zr   <= w_next_zr;
            r_zi   <= w_next_zi;
            r_iter <= r_iter + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_iter    = r_out_iter;
  assign out_escaped = r_out_escaped;

endmodule
`default_nettype wire

// File: tb/tb_mandelbrot_iter_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mandelbrot_iter_ctrl: scoreboard bench with reference model        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_mandelbrot_iter_ctrl;
  import mandelbrot_pkg::*;

  localparam int W    = 8;
  localparam int IW   = 6;
  localparam int FRAC = W - 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_cr;
  logic [W-1:0]  in_ci;
  logic [IW-1:0] in_max_iter;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_iter;
  logic          out_escaped;

  mandelbrot_iter_ctrl #(
    .WIDTH  (W),
    .ITER_W (IW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_cr       (in_cr),
    .in_ci       (in_ci),
    .in_max_iter (in_max_iter),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_iter    (out_iter),
    .out_escaped (out_escaped)
  );

  always #5 clk = ~clk;

  typedef struct {
    int iter;
    int esc;
    int cycles;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int wrap8(input int x);
    logic [7:0] b;
    b = x[7:0];
    return $signed(b);
  endfunction

  // Reference: integer fixed-point with ONE = 64, wraparound to 8 bits.
  function automatic exp_t model(input logic [7:0] cr8, input logic [7:0] ci8, input int mi);
    exp_t e;
    int   cr, ci, zr, zi, nzr, it;
    cr = $signed(cr8);
    ci = $signed(ci8);
    zr = 0;
    zi = 0;
    it = 0;
    e.iter = 0;
    e.esc  = 0;
    while (1) begin
      if (zr*zr + zi*zi > 4*ONE*ONE) begin
        e.iter = it; e.esc = 1; break;
      end
      if (it == mi) begin
        e.iter = mi; e.esc = 0; break;
      end
      nzr = wrap8(((zr*zr - zi*zi) >>> FRAC) + cr);
      zi  = wrap8(((2*zr*zi) >>> FRAC) + ci);
      zr  = nzr;
      it++;
    end
    e.cycles = e.iter + 1;
    return e;
  endfunction

  task automatic start_job(input logic [7:0] cr, input logic [7:0] ci, input int mi, output bit ok);
    int wait_cyc;
    wait_cyc = 0;
    while (in_ready !== 1'b1 && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    ok = (in_ready === 1'b1);
    if (!ok) begin
      check_eq("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      return;
    end
    in_valid    = 1'b1;
    in_cr       = cr;
    in_ci       = ci;
    in_max_iter = mi[IW-1:0];
    @(negedge clk);
    // Scramble inputs while busy; the latched job must be unaffected.
    in_valid    = 1'b0;
    in_cr       = 8'($urandom);
    in_ci       = 8'($urandom);
    in_max_iter = 6'($urandom);
  endtask

  task automatic run_job(input logic [7:0] cr, input logic [7:0] ci, input int mi,
                         input int bp, input string tag);
    exp_t e;
    int   cyc;
    bit   ok;
    sb.push_back(model(cr, ci, mi));
    start_job(cr, ci, mi, ok);
    if (!ok) begin
      void'(sb.pop_front());
      return;
    end
    cyc = 1;
    while (out_valid !== 1'b1 && cyc <= 100) begin
      @(negedge clk);
      if (out_valid !== 1'b1) cyc++;
    end
    if (out_valid !== 1'b1) begin
      check_eq({tag, "_result_timeout"}, {31'd0, out_valid}, 32'd1);
      void'(sb.pop_front());
      return;
    end
    check_eq({tag, "_run_cycles"}, cyc, sb[0].cycles);
    for (int i = 0; i < bp; i++) begin
      check_eq({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check_eq({tag, "_hold_iter"}, {26'd0, out_iter}, sb[0].iter);
      check_eq({tag, "_hold_esc"}, {31'd0, out_escaped}, sb[0].esc);
      check_eq({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    e = sb.pop_front();
    check_eq({tag, "_iter"}, {26'd0, out_iter}, e.iter);
    check_eq({tag, "_esc"}, {31'd0, out_escaped}, e.esc);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_idle_in_ready"}, {31'd0, in_ready}, 32'd1);
    check_eq({tag, "_idle_out_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic reset_mid_run();
    bit ok;
    int seen;
    sb.push_back(model(8'h00, 8'h00, 20));
    start_job(8'h00, 8'h00, 20, ok);
    if (!ok) begin
      sb.delete();
      return;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    sb.delete();
    check_eq("rst_run_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_run_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_run_out_iter", {26'd0, out_iter}, 32'd0);
    check_eq("rst_run_out_esc", {31'd0, out_escaped}, 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    out_ready = 1'b0;
    check_eq("rst_run_no_result", seen, 0);
    check_eq("rst_run_idle", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_cr       = '0;
    in_ci       = '0;
    in_max_iter = '0;
    out_ready   = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("reset_out_iter", {26'd0, out_iter}, 32'd0);
    check_eq("reset_out_esc", {31'd0, out_escaped}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_job(8'h00, 8'h00, 20, 1, "zero_c_limit");
    check_eq("zero_c_const_iter", sb.size(), 0);
    run_job(8'h35, 8'hA7, 0, 0, "max_iter_zero");
    run_job(8'h60, 8'h60, 20, 5, "escape_1p5");
    reset_mid_run();

    for (int j = 0; j < 500; j++) begin
      run_job(8'($urandom), 8'($urandom), int'($urandom_range(0, 63)),
              int'($urandom_range(0, 3)), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
